sec_codeword_assembler: RTL
===========================

// Module: sec_codeword_assembler
// PURPOSE
//  Upstream feeder for the 32-bit single-error-correcting (SEC) corrector stage.
//  - Collects a byte stream into one codeword: 32 data bits plus 8 check bits.
//  - Presents each codeword in parallel, with a valid/ready handshake, to the corrector's
//    data, check and correction-enable inputs.
//  - Detects malformed frames and byte-gap timeouts, and drops the bytes involved.
// PARAMETERS
//  TIMEOUT   255  max idle cycles between bytes inside a frame before abort (1..65535)
//  CNT_W     16   width of the good-frame counter
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      async active-low reset
//  in_valid     in   1      byte valid
//  in_ready     out  1      byte accepted when in_valid&in_ready
//  in_data      in   8      byte payload
//  in_last      in   1      marks final byte of a codeword
//  in_corr_en   in   1      correction enable; sampled on the first byte of a frame
//  out_valid    out  1      codeword valid to corrector
//  out_ready    in   1      corrector accepts when out_valid&out_ready
//  out_data     out  32     codeword data bits
//  out_chk      out  8      codeword check bits
//  out_corr_en  out  1      enable forwarded with codeword
//  frame_err    out  1      1-cycle pulse on length error or timeout
//  frame_cnt    out  CNT_W  count of codewords handed off; wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset values: all outputs 0 except in_ready=1. FSM=IDLE, counters=0.
//  Frame length is FLEN: 5 bytes, or 4 with SEC_CHK_GEN_EN.
//  Byte order: byte0->data[7:0] ... byte3->data[31:24]; byte4->chk[7:0].
//  Two registers:
//   - assembly register (ASM)
//   - output register (OUT, single entry)
//  FSM states:
//   - IDLE: waiting for byte0. On accept, capture byte0, latch in_corr_en, go COLLECT
//     with idx=1.
//   - COLLECT: each accepted byte is written at idx, then idx++.
//     - in_last on idx<FLEN-1 -> frame_err, discard, go IDLE.
//     - Byte at idx=FLEN-1 with in_last=1 -> frame complete, go IDLE.
//     - Byte at idx=FLEN-1 with in_last=0 -> frame_err, go DRAIN.
//   - DRAIN: accept and discard bytes until a byte with in_last is accepted, then go IDLE.
//     No timeout applies in DRAIN.
//   - Timeout (COLLECT only):
//     - gap counter clears on every accepted byte and increments on every other cycle;
//     - when it reaches TIMEOUT: frame_err, discard, go IDLE;
//     - a byte arriving in that same cycle is treated as byte0 of a new frame.
//  Handoff:
//   - A completed frame moves to OUT on the cycle after its last byte if OUT is empty,
//     or if OUT empties in that cycle (out_valid&out_ready).
//   - Otherwise ASM holds the frame and in_ready=0 until the transfer.
//   - Result: back-to-back frames run at 1 byte/clk with zero-bubble handoff.
//  OUT register:
//   - out_* are stable while out_valid=1 and out_ready=0.
//   - out_valid drops the cycle after acceptance unless refilled in that same cycle.
//  frame_cnt increments on every out_valid&out_ready.
//  in_ready is low only while ASM holds a completed frame that OUT cannot take.
//  frame_err is never asserted for a frame that is also handed off.
//  Reset mid-frame: partial ASM contents and OUT are dropped; no output pulse is generated.
// CONFIGURATION
//  SEC_CHK_GEN_EN defined:
//   - FLEN=4;
//   - out_chk is computed at handoff: out_chk[k] = XOR of data[i] for all i with i%8==k;
//   - checks are generated locally.
//  Undefined:
//   - FLEN=5;
//   - out_chk is taken from byte4 unchanged.
// TESTING
//  - Frame 5 bytes 0x11,22,33,44,A5 (last on byte4), corr_en=1, out_ready=1 ->
//    out_data=0x44332211, out_chk=0xA5, out_corr_en=1, frame_cnt=1.
//  - Two frames back-to-back with out_ready=0 for 10 cycles -> first frame held stable,
//    in_ready=0 after second frame completes; release -> both delivered in order.
//  - in_last on byte2 -> frame_err pulse, no out_valid; next good frame delivered intact.
//  - Byte gap of TIMEOUT cycles after byte1 -> frame_err; following 5 bytes form a
//    good frame.
//  - rst_n low during byte3 and while out_valid=1 -> out_valid=0, in_ready=1,
//    frame_cnt=0 immediately.
//  - SEC_CHK_GEN_EN defined: bytes 0x01,00,00,80 -> out_chk=0x81;
//    frame_cnt wraps 0xFFFF->0 on the next handoff.

Source files
------------

// File: rtl/sec_codeword_assembler.sv
// Byte-stream to SEC codeword assembler: 4 data bytes + check byte (or locally generated
// checks when SEC_CHK_GEN_EN is defined), handed off through a single-entry output register.
module sec_codeword_assembler #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  input  logic             in_corr_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [7:0]       out_chk,
  output logic             out_corr_en,
  output logic             frame_err,
  output logic [CNT_W-1:0] frame_cnt
);

`ifdef SEC_CHK_GEN_EN
  localparam int unsigned FLEN = 4;
`else
  localparam int unsigned FLEN = 5;
`endif
  localparam logic [2:0] LastIdx = 3'(FLEN - 1);

  typedef enum logic [1:0] {StIdle, StCollect, StDrain} state_e;

  state_e             st_q, st_d;
  logic [2:0]         idx_q, idx_d;
  logic [15:0]        gap_q, gap_d;
  logic [31:0]        asm_data_q, asm_data_d;
  logic               asm_corr_q, asm_corr_d;
  logic               asm_full_q, asm_full_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        out_data_q, out_data_d;
  logic [7:0]         out_chk_q, out_chk_d;
  logic               out_corr_q, out_corr_d;
  logic               frame_err_q, frame_err_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [7:0]         xfer_chk;

  logic in_fire, out_fire, xfer, timed_out, start;

`ifdef SEC_CHK_GEN_EN
  assign xfer_chk = asm_data_q[7:0] ^ asm_data_q[15:8] ^ asm_data_q[23:16] ^ asm_data_q[31:24];
`else
  logic [7:0] asm_chk_q, asm_chk_d;
  assign xfer_chk = asm_chk_q;
`endif

  assign out_fire  = out_valid_q & out_ready;
  // A completed frame moves to OUT when OUT is empty or emptying this cycle.
  assign xfer      = asm_full_q & (~out_valid_q | out_ready);
  assign in_ready  = ~asm_full_q | xfer;
  assign in_fire   = in_valid & in_ready;
  assign timed_out = (st_q == StCollect) && (gap_q == 16'(TIMEOUT));

  always_comb begin
    st_d        = st_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    asm_data_d  = asm_data_q;
    asm_corr_d  = asm_corr_q;
    asm_full_d  = asm_full_q & ~xfer;
    frame_err_d = 1'b0;
    start       = 1'b0;
`ifndef SEC_CHK_GEN_EN
    asm_chk_d   = asm_chk_q;
`endif

    unique case (st_q)
      StIdle: start = in_fire;
      StCollect: begin
        if (timed_out) begin
          // A byte arriving on the timeout cycle opens a new frame.
          frame_err_d = 1'b1;
          st_d        = StIdle;
          start       = in_fire;
        end else if (in_fire) begin
          gap_d = '0;
          idx_d = idx_q + 3'd1;
          case (idx_q)
            3'd1: asm_data_d[15:8]  = in_data;
            3'd2: asm_data_d[23:16] = in_data;
            3'd3: asm_data_d[31:24] = in_data;
`ifndef SEC_CHK_GEN_EN
            3'd4: asm_chk_d         = in_data;
`endif
            default: ;
          endcase
          if (idx_q == LastIdx) begin
            if (in_last) begin
              asm_full_d = 1'b1;
              st_d       = StIdle;
            end else begin
              frame_err_d = 1'b1;
              st_d        = StDrain;
            end
          end else if (in_last) begin
            frame_err_d = 1'b1;
            st_d        = StIdle;
          end
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      StDrain: if (in_fire && in_last) st_d = StIdle;
      default: st_d = StIdle;
    endcase

    if (start) begin
      asm_data_d[7:0] = in_data;
      asm_corr_d      = in_corr_en;
      idx_d           = 3'd1;
      gap_d           = '0;
      if (in_last) begin
        frame_err_d = 1'b1;
        st_d        = StIdle;
      end else begin
        st_d = StCollect;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q & ~out_ready;
    out_data_d  = out_data_q;
    out_chk_d   = out_chk_q;
    out_corr_d  = out_corr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = asm_data_q;
      out_chk_d   = xfer_chk;
      out_corr_d  = asm_corr_q;
    end
    frame_cnt_d = frame_cnt_q + {{(CNT_W-1){1'b0}}, out_fire};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= StIdle;
      idx_q       <= '0;
      gap_q       <= '0;
      asm_data_q  <= '0;
      asm_corr_q  <= 1'b0;
      asm_full_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chk_q   <= '0;
      out_corr_q  <= 1'b0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      st_q        <= st_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      asm_data_q  <= asm_data_d;
      asm_corr_q  <= asm_corr_d;
      asm_full_q  <= asm_full_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chk_q   <= out_chk_d;
      out_corr_q  <= out_corr_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

`ifndef SEC_CHK_GEN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) asm_chk_q <= '0;
    else        asm_chk_q <= asm_chk_d;
  end
`endif

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_chk     = out_chk_q;
  assign out_corr_en = out_corr_q;
  assign frame_err   = frame_err_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
